lab4_cpu_oci_trace_capture: RTL and testbench

//  Parametrised successor to the OCI debug-trace test-bench sink. Captures trace

---
 rtl/lab4_oci_trace_pkg.sv | 18 +
 rtl/lab4_cpu_oci_trace_capture_if.sv | 26 ++
 rtl/lab4_oci_trace_fifo.sv | 48 ++++
 rtl/lab4_cpu_oci_trace_capture.sv | 88 ++++++++
 tb/tb_lab4_cpu_oci_trace_capture.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/lab4_oci_trace_pkg.sv
// Shared types and default widths for the OCI trace capture sink.
package lab4_oci_trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FLUSH   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  localparam int unsigned DEF_DCT_W   = 30;
  localparam int unsigned DEF_CNT_W   = 4;
  localparam int unsigned DEF_DEPTH   = 16;
  localparam int unsigned DEF_OVF_W   = 16;
  localparam int unsigned DEF_FRAME_W = DEF_CNT_W + DEF_DCT_W;
  localparam logic [DEF_OVF_W-1:0] DEF_OVF_SAT = '1;

endpackage

// File: rtl/lab4_cpu_oci_trace_capture_if.sv
// Trace-in and frame-out signals of the capture sink, bundled for port reuse.
interface lab4_cpu_oci_trace_capture_if
  import lab4_oci_trace_pkg::*;
#(
  parameter int unsigned DCT_W = DEF_DCT_W,
  parameter int unsigned CNT_W = DEF_CNT_W
);
  logic                   dct_valid;
  logic [DCT_W-1:0]       dct_buffer;
  logic [CNT_W-1:0]       dct_count;
  // A frame transfers on a rising edge where out_valid && out_ready; while
  // out_ready is low the sink holds out_valid and out_data unchanged.
  logic                   out_valid;
  logic                   out_ready;
  logic [CNT_W+DCT_W-1:0] out_data;

  modport master (
    output dct_valid, dct_buffer, dct_count, out_ready,
    input  out_valid, out_data
  );

  modport slave (
    input  dct_valid, dct_buffer, dct_count, out_ready,
    output out_valid, out_data
  );
endinterface

// File: rtl/lab4_oci_trace_fifo.sv
// Show-ahead FIFO with registered level; accepts push+pop in the same cycle when full.
module lab4_oci_trace_fifo #(
  parameter int unsigned W     = 34,
  parameter int unsigned DEPTH = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       clear_i,
  input  logic                       push_i,
  input  logic [W-1:0]               wdata_i,
  input  logic                       pop_i,
  output logic [W-1:0]               rdata_o,
  output logic                       empty_o,
  output logic                       full_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   level_q;

  always_ff @(posedge clk) begin
    if (!reset_n || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({push_i, pop_i})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  // When full, write and read slots coincide; the head is read before the edge overwrites it.
  always_ff @(posedge clk) begin
    if (reset_n && !clear_i && push_i) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign empty_o = (level_q == '0);
  assign full_o  = (level_q == (AW+1)'(DEPTH));
  assign level_o = level_q;
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];
endmodule

// File: rtl/lab4_cpu_oci_trace_capture.sv
// OCI debug-trace sink: captures frames, counts overflow drops, sequences end-of-test.
module lab4_cpu_oci_trace_capture
  import lab4_oci_trace_pkg::*;
#(
  parameter int unsigned DCT_W = DEF_DCT_W,
  parameter int unsigned CNT_W = DEF_CNT_W,
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned OVF_W = DEF_OVF_W
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       arm_i,
  input  logic                       test_ending_i,
  lab4_cpu_oci_trace_capture_if.slave trace_if,
  output logic [$clog2(DEPTH):0]     fill_level_o,
  output logic [OVF_W-1:0]           overflow_cnt_o,
  output logic                       test_has_ended_o,
  output state_t                     state_o
);
  localparam int unsigned ADDR_W  = $clog2(DEPTH);
  localparam int unsigned FRAME_W = CNT_W + DCT_W;
  localparam logic [OVF_W-1:0] OVF_MAX = '1;

  state_t            state_q, state_d;
  logic [OVF_W-1:0]  ovf_q, ovf_d;
  logic              fifo_empty, fifo_full, fifo_clear, fifo_push, fifo_pop;
  logic              frame_offer, frame_drop, last_pop;
  logic [ADDR_W:0]   fifo_level;
  logic [FRAME_W-1:0] fifo_rdata;

  assign frame_offer = (state_q == ST_CAPTURE) && trace_if.dct_valid &&
                       (trace_if.dct_count != '0);
  assign fifo_pop    = !fifo_empty && trace_if.out_ready;
  assign fifo_push   = frame_offer && (!fifo_full || fifo_pop);
  assign frame_drop  = frame_offer && fifo_full && !fifo_pop;
  assign fifo_clear  = arm_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
  assign last_pop    = fifo_pop && (fifo_level == (ADDR_W+1)'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:    if (arm_i) state_d = ST_CAPTURE;
      ST_CAPTURE: if (test_ending_i) state_d = ST_FLUSH;
      ST_FLUSH:   if (fifo_empty || last_pop) state_d = ST_DONE;
      ST_DONE:    if (arm_i) state_d = ST_CAPTURE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    ovf_d = ovf_q;
    if (fifo_clear) ovf_d = '0;
    else if (frame_drop && (ovf_q != OVF_MAX)) ovf_d = ovf_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      ovf_q   <= '0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  lab4_oci_trace_fifo #(
    .W     (FRAME_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .clear_i (fifo_clear),
    .push_i  (fifo_push),
    .wdata_i ({trace_if.dct_count, trace_if.dct_buffer}),
    .pop_i   (fifo_pop),
    .rdata_o (fifo_rdata),
    .empty_o (fifo_empty),
    .full_o  (fifo_full),
    .level_o (fifo_level)
  );

  assign trace_if.out_valid = !fifo_empty;
  assign trace_if.out_data  = fifo_rdata;
  assign fill_level_o       = fifo_level;
  assign overflow_cnt_o     = ovf_q;
  assign test_has_ended_o   = (state_q == ST_DONE);
  assign state_o            = state_q;
endmodule

// File: tb/tb_lab4_cpu_oci_trace_capture.sv
// Randomised and directed bench against a queue-based reference of the trace sink.
module tb_lab4_cpu_oci_trace_capture;
  import lab4_oci_trace_pkg::*;

  localparam int DCT_W   = 30;
  localparam int CNT_W   = 4;
  localparam int DEPTH   = 16;
  localparam int OVF_W   = 3;
  localparam int FW      = CNT_W + DCT_W;
  localparam int OVF_TOP = (1 << OVF_W) - 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic arm = 1'b0;
  logic test_ending = 1'b0;
  always #5 clk = ~clk;

  lab4_cpu_oci_trace_capture_if #(.DCT_W(DCT_W), .CNT_W(CNT_W)) tif ();

  logic [$clog2(DEPTH):0] fill_level;
  logic [OVF_W-1:0]       overflow_cnt;
  logic                   test_has_ended;
  state_t                 dut_state;

  lab4_cpu_oci_trace_capture #(
    .DCT_W(DCT_W), .CNT_W(CNT_W), .DEPTH(DEPTH), .OVF_W(OVF_W)
  ) dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .arm_i            (arm),
    .test_ending_i    (test_ending),
    .trace_if         (tif.slave),
    .fill_level_o     (fill_level),
    .overflow_cnt_o   (overflow_cnt),
    .test_has_ended_o (test_has_ended),
    .state_o          (dut_state)
  );

  // ---------------- scoreboard / reference ----------------
  logic [FW-1:0] exp_q[$];
  int  exp_ovf   = 0;
  int  phase     = 0;  // 0 waiting for arm, 1 capturing, 2 flushing, 3 finished
  int  n_checks  = 0;
  int  n_pass    = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
  endtask

  task automatic model_edge();
    int  pre;
    bit  do_pop, offer;
    if (!reset_n) begin
      exp_q.delete();
      exp_ovf = 0;
      phase   = 0;
      return;
    end
    pre    = exp_q.size();
    do_pop = (pre > 0) && tif.out_ready;
    offer  = (phase == 1) && tif.dct_valid && (tif.dct_count != 0);
    if (do_pop) void'(exp_q.pop_front());
    if (offer) begin
      if (pre < DEPTH || do_pop) exp_q.push_back({tif.dct_count, tif.dct_buffer});
      else if (exp_ovf < OVF_TOP) exp_ovf++;
    end
    case (phase)
      0, 3: if (arm) begin
        phase = 1;
        exp_q.delete();
        exp_ovf = 0;
      end
      1: if (test_ending) phase = 2;
      2: if (exp_q.size() == 0) phase = 3;
      default: phase = 0;
    endcase
  endtask

  task automatic step();
    logic [FW-1:0] head;
    @(posedge clk);
    model_edge();
    #1;
    head = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("out_valid",      64'(tif.out_valid),   64'(exp_q.size() > 0));
    check("out_data",       64'(tif.out_data),    64'(head));
    check("fill_level",     64'(fill_level),      64'(exp_q.size()));
    check("overflow_cnt",   64'(overflow_cnt),    64'(exp_ovf));
    check("test_has_ended", 64'(test_has_ended),  64'(phase == 3));
  endtask

  // ---------------- driver ----------------
  task automatic drive(input bit a, input bit v, input logic [CNT_W-1:0] c,
                       input logic [DCT_W-1:0] b, input bit e, input bit r);
    arm            = a;
    tif.dct_valid  = v;
    tif.dct_count  = c;
    tif.dct_buffer = b;
    test_ending    = e;
    tif.out_ready  = r;
    step();
  endtask

  task automatic rand_frame(input bit e, input bit r);
    drive(1'b0, 1'b1, CNT_W'($urandom_range(1, 15)), DCT_W'($urandom), e, r);
  endtask

  task automatic idle(input int n, input bit r);
    for (int i = 0; i < n; i++) drive(1'b0, 1'b0, '0, '0, 1'b0, r);
  endtask

  initial begin
    tif.dct_valid  = 1'b0;
    tif.dct_count  = '0;
    tif.dct_buffer = '0;
    tif.out_ready  = 1'b0;

    // reset state
    reset_n = 1'b0;
    idle(2, 1'b0);
    reset_n = 1'b1;
    idle(1, 1'b1);

    // three frames streamed through with the consumer ready
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b1);
    for (int i = 1; i <= 3; i++) drive(1'b0, 1'b1, CNT_W'(i), DCT_W'(i), 1'b0, 1'b1);
    idle(3, 1'b1);

    // overfill: 20 frames into 16 slots, then push+pop while full, then drain
    for (int i = 0; i < 20; i++) rand_frame(1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'd5, 30'h55, 1'b0, 1'b1);
    idle(18, 1'b1);

    // empty frames are discarded
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, '0, DCT_W'($urandom), 1'b0, 1'b1);

    // end-of-test: 5 frames, 6th alongside test_ending, drain, later frames ignored
    for (int i = 0; i < 5; i++) rand_frame(1'b0, 1'b0);
    drive(1'b0, 1'b1, 4'd6, 30'h6, 1'b1, 1'b0);
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) rand_frame(1'b0, 1'b1);

    // re-arm from DONE clears the earlier overflow count, then saturate it
    drive(1'b1, 1'b0, '0, '0, 1'b0, 1'b0);
    for (int i = 0; i < 26; i++) rand_frame(1'b0, 1'b0);

    // flush down to 4 stored frames, then reset mid-flush
    drive(1'b0, 1'b0, '0, '0, 1'b1, 1'b0);
    idle(12, 1'b1);
    idle(2, 1'b0);
    reset_n = 1'b0;
    idle(1, 1'b0);
    reset_n = 1'b1;
    idle(2, 1'b1);

    // random traffic with occasional arm, test_ending and reset
    for (int blk = 0; blk < 8; blk++) begin
      int ready_pct;
      ready_pct = (blk % 2 == 0) ? 25 : 80;
      for (int i = 0; i < 80; i++) begin
        reset_n = ($urandom_range(0, 199) != 0);
        drive($urandom_range(0, 15) == 0,
              $urandom_range(0, 3) != 0,
              CNT_W'($urandom_range(0, 15)),
              DCT_W'($urandom),
              $urandom_range(0, 39) == 0,
              $urandom_range(0, 99) < ready_pct);
      end
      reset_n = 1'b1;
    end
    idle(20, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
